umips_lsu: RTL and testbench

Memory-stage load/store unit for the umips core. Accepts one load or store per access from the EX/MEM pipeline register, aligns store data and byte enables big-endian onto the 32-bit data bus, runs the request/acknowledge handshake, and stalls the pipeline until completion. It captures the raw read word plus the byte-index and extension controls, registered, for the downstream load byte-select stage. It also flags misaligned addresses and bus timeouts.

---
 rtl/umips_lsu_pkg.sv | 24 ++
 rtl/umips_store_align.sv | 45 ++++
 rtl/umips_lsu.sv | 143 ++++++++++++++
 tb/tb_umips_lsu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/umips_lsu_pkg.sv
// Shared definitions for the umips load/store unit: access size encodings,
// controller state encoding and the alignment rule.
package umips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Encoding 2'b11 falls through to the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/umips_store_align.sv
// Big-endian store lane steering: places right-justified store data onto the
// byte lanes selected by size and address offset, unused lanes driven to zero.
module umips_store_align
  import umips_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Lane gi carries bits [8gi+7:8gi], which is big-endian byte offset 3-gi.
      localparam logic [1:0] BOFF = 2'(3 - gi);
      logic       hit;
      logic [7:0] src;

      always_comb begin
        hit = 1'b0;
        src = 8'h00;
        case (size)
          SZ_BYTE: begin
            hit = (off == BOFF);
            src = wdata[7:0];
          end
          SZ_HALF: begin
            hit = (off[1] == BOFF[1]);
            src = (gi % 2 == 1) ? wdata[15:8] : wdata[7:0];
          end
          default: begin
            hit = 1'b1;
            src = wdata[8*gi +: 8];
          end
        endcase
      end

      assign be[gi]              = hit;
      assign lane_data[8*gi +: 8] = hit ? src : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/umips_lsu.sv
// Memory-stage load/store unit: issues one bus request per access, stalls the
// pipeline until ack or timeout, and registers load controls for byte select.
module umips_lsu
  import umips_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] d_addr,
  output logic        d_req,
  output logic        d_we,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] ld_word,
  output logic [1:0]  ld_byte_n,
  output logic        ld_sign_sel,
  output logic        ld_byte_sel,
  output logic        ld_word_sel
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  lsu_state_e    state_reg;
  logic [1:0]    size_reg;
  logic          sign_reg;
  logic [1:0]    off_reg;
  logic [TW-1:0] timer_reg;

  logic [3:0]    be_algn;
  logic [31:0]   wd_algn;
  logic          access;
  logic          misal;
  logic          access_ok;

  umips_store_align u_align (
    .size      (mem_size),
    .off       (mem_addr[1:0]),
    .wdata     (mem_wdata),
    .be        (be_algn),
    .lane_data (wd_algn)
  );

  assign access    = mem_rd | mem_wr;
  assign misal     = is_misaligned(mem_size, mem_addr[1:0]);
  assign access_ok = (state_reg == ST_IDLE) && access && !misal;
  assign addr_err  = (state_reg == ST_IDLE) && access && misal;
  assign stall     = access_ok || (state_reg == ST_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      d_addr      <= 32'h0;
      d_req       <= 1'b0;
      d_we        <= 1'b0;
      d_be        <= 4'h0;
      d_wdata     <= 32'h0;
      bus_err     <= 1'b0;
      ld_word     <= 32'h0;
      ld_byte_n   <= 2'b00;
      ld_sign_sel <= 1'b0;
      ld_byte_sel <= 1'b0;
      ld_word_sel <= 1'b0;
      size_reg    <= SZ_BYTE;
      sign_reg    <= 1'b0;
      off_reg     <= 2'b00;
      timer_reg   <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (access_ok) begin
            d_addr    <= {mem_addr[31:2], 2'b00};
            d_be      <= be_algn;
            d_wdata   <= wd_algn;
            d_we      <= mem_wr;
            d_req     <= 1'b1;
            size_reg  <= mem_size;
            sign_reg  <= mem_sign;
            off_reg   <= mem_addr[1:0];
            timer_reg <= '0;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (d_ack) begin
            d_req     <= 1'b0;
            d_we      <= 1'b0;
            state_reg <= ST_DONE;
            if (!d_we) begin
              ld_word     <= d_rdata;
              ld_sign_sel <= sign_reg;
              case (size_reg)
                SZ_BYTE: begin
                  ld_byte_n   <= off_reg;
                  ld_byte_sel <= 1'b0;
                  ld_word_sel <= 1'b1;
                end
                SZ_HALF: begin
                  ld_byte_n   <= {1'b0, off_reg[1]};
                  ld_byte_sel <= 1'b1;
                  ld_word_sel <= 1'b1;
                end
                default: begin
                  ld_byte_n   <= 2'b00;
                  ld_byte_sel <= 1'b0;
                  ld_word_sel <= 1'b0;
                end
              endcase
            end
          end else if ((TIMEOUT != 0) && (timer_reg == TO_LAST)) begin
            // Abort: the load controls keep the last completed load.
            d_req     <= 1'b0;
            d_we      <= 1'b0;
            bus_err   <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umips_lsu.sv
// Self-checking bench for umips_lsu: directed vector table, reset and
// misalignment sequences, and randomized accesses against a behavioural model.
module tb_umips_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] d_addr, d_wdata, d_rdata, ld_word;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_be;
  logic        stall, addr_err, bus_err;
  logic [1:0]  ld_byte_n;
  logic        ld_sign_sel, ld_byte_sel, ld_word_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the registered load controls.
  logic [31:0] m_word;
  logic [1:0]  m_byte_n;
  logic        m_sign, m_bsel, m_wsel;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;      // -1: never acknowledge
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_stalls;
    int          exp_reqs;
    logic        exp_bus_err;
  } vec_t;

  umips_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sign(mem_sign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .d_addr(d_addr), .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall(stall), .addr_err(addr_err),
    .bus_err(bus_err), .ld_word(ld_word), .ld_byte_n(ld_byte_n),
    .ld_sign_sel(ld_sign_sel), .ld_byte_sel(ld_byte_sel), .ld_word_sel(ld_word_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_ld(input string nm);
    check({nm, " ld_word"}, ld_word, m_word);
    check({nm, " ld_byte_n"}, {30'b0, ld_byte_n}, {30'b0, m_byte_n});
    check({nm, " ld_sign_sel"}, {31'b0, ld_sign_sel}, {31'b0, m_sign});
    check({nm, " ld_byte_sel"}, {31'b0, ld_byte_sel}, {31'b0, m_bsel});
    check({nm, " ld_word_sel"}, {31'b0, ld_word_sel}, {31'b0, m_wsel});
  endtask

  // Reference: big-endian lane placement from size and byte offset.
  function automatic vec_t make_vec(input string nm, input logic rd, input logic [1:0] size,
                                    input logic sign, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    input int waits);
    vec_t v;
    int k;
    k = int'(addr[1:0]);
    v.name = nm; v.rd = rd; v.wr = !rd; v.size = size; v.sign = sign;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    if (size == 2'b00) begin
      v.exp_be    = 4'b1000 >> k;
      v.exp_wdata = {24'b0, wdata[7:0]} << (8 * (3 - k));
    end else if (size == 2'b01) begin
      v.exp_be    = 4'b1100 >> k;
      v.exp_wdata = {16'b0, wdata[15:0]} << (8 * (2 - k));
    end else begin
      v.exp_be    = 4'b1111;
      v.exp_wdata = wdata;
    end
    v.exp_stalls  = (waits < 0) ? TO + 1 : waits + 2;
    v.exp_reqs    = (waits < 0) ? TO : waits + 1;
    v.exp_bus_err = (waits < 0);
    return v;
  endfunction

  // Starts at posedge+1; leaves the inputs as they were at the DONE cycle.
  task automatic run_access(input vec_t v);
    int  stalls = 0;
    int  reqs   = 0;
    bit  done   = 0;
    @(posedge clk); #1;
    mem_rd = v.rd; mem_wr = v.wr; mem_size = v.size; mem_sign = v.sign;
    mem_addr = v.addr; mem_wdata = v.wdata; d_rdata = v.rdata; d_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (d_req) begin
        reqs++;
        if (reqs == 1) begin
          check({v.name, " d_addr"}, d_addr, {v.addr[31:2], 2'b00});
          check({v.name, " d_be"}, {28'b0, d_be}, {28'b0, v.exp_be});
          check({v.name, " d_we"}, {31'b0, d_we}, {31'b0, v.wr});
          if (v.wr) check({v.name, " d_wdata"}, d_wdata, v.exp_wdata);
        end
      end
      d_ack = d_req && (v.waits >= 0) && (reqs == v.waits + 1);
      if (!stall && !d_req && reqs > 0) done = 1;
    end
    d_ack = 1'b0;
    check({v.name, " completed"}, {31'b0, done}, 32'd1);
    if (v.rd && v.waits >= 0) begin
      m_word = v.rdata; m_sign = v.sign;
      if (v.size == 2'b00) begin
        m_byte_n = v.addr[1:0]; m_bsel = 1'b0; m_wsel = 1'b1;
      end else if (v.size == 2'b01) begin
        m_byte_n = {1'b0, v.addr[1]}; m_bsel = 1'b1; m_wsel = 1'b1;
      end else begin
        m_byte_n = 2'b00; m_bsel = 1'b0; m_wsel = 1'b0;
      end
    end
    check({v.name, " stalls"}, stalls, v.exp_stalls);
    check({v.name, " reqs"}, reqs, v.exp_reqs);
    check({v.name, " bus_err"}, {31'b0, bus_err}, {31'b0, v.exp_bus_err});
    check_ld(v.name);
    $display("txn %s rd=%0b addr=%h be=%b stalls=%0d reqs=%0d bus_err=%0b ld_word=%h",
             v.name, v.rd, v.addr, d_be, stalls, reqs, bus_err, ld_word);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; d_ack = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    rst = 1'b1; mem_rd = 0; mem_wr = 0; mem_size = 0; mem_sign = 0;
    mem_addr = 0; mem_wdata = 0; d_ack = 0; d_rdata = 0;
    m_word = 0; m_byte_n = 0; m_sign = 0; m_bsel = 0; m_wsel = 0;
    repeat (2) @(negedge clk);
    check("reset d_req", {31'b0, d_req}, 32'd0);
    check("reset d_we", {31'b0, d_we}, 32'd0);
    check("reset d_be", {28'b0, d_be}, 32'd0);
    check("reset d_addr", d_addr, 32'd0);
    check("reset d_wdata", d_wdata, 32'd0);
    check("reset bus_err", {31'b0, bus_err}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check_ld("reset");
    rst = 1'b0;

    // name rd size sign addr wdata rdata waits
    vecs[0] = make_vec("st_byte_1003", 0, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    vecs[1] = make_vec("ld_half_2002", 1, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h1234_8001, 3);
    vecs[2] = make_vec("ld_timeout", 1, 2'b10, 0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, -1);
    vecs[3] = make_vec("st_half_0010", 0, 2'b01, 0, 32'h0000_0010, 32'h0000_BEEF, 32'h0, 1);
    vecs[4] = make_vec("st_word_sz3", 0, 2'b11, 0, 32'h0000_0020, 32'h1122_3344, 32'h0, 0);
    vecs[5] = make_vec("ld_byte_0041", 1, 2'b00, 0, 32'h0000_0041, 32'h0, 32'hCAFE_F00D, 2);
    // Hand-computed expectations for the first two vectors.
    vecs[0].exp_be = 4'b0001; vecs[0].exp_wdata = 32'h0000_00A5; vecs[0].exp_stalls = 2;
    vecs[1].exp_be = 4'b0011; vecs[1].exp_stalls = 5;
    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i]);
      go_idle();
    end
    check("half ld_byte_n", {30'b0, ld_byte_n}, 32'd1);

    // Misaligned word load: one-cycle error, no request.
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_size = 2'b10; mem_addr = 32'h0000_0006;
    @(negedge clk);
    check("misal addr_err", {31'b0, addr_err}, 32'd1);
    check("misal stall", {31'b0, stall}, 32'd0);
    go_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("misal d_req", {31'b0, d_req}, 32'd0);
      check("misal addr_err clear", {31'b0, addr_err}, 32'd0);
    end
    $display("txn misaligned_word_0006 addr_err checked");

    // Reset mid-REQ, then a stray ack, then a normal load.
    @(posedge clk); #1;
    mem_rd = 1'b1; mem_size = 2'b10; mem_sign = 1'b0; mem_addr = 32'h0000_0100;
    begin
      bit seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (d_req) seen = 1;
      end
      check("rst_mid d_req seen", {31'b0, seen}, 32'd1);
    end
    rst = 1'b1; #1;
    check("rst_mid d_req drop", {31'b0, d_req}, 32'd0);
    mem_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_word = 0; m_byte_n = 0; m_sign = 0; m_bsel = 0; m_wsel = 0;
    d_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stray ack d_req", {31'b0, d_req}, 32'd0);
      check("stray ack stall", {31'b0, stall}, 32'd0);
    end
    d_ack = 1'b0;
    check_ld("after rst");
    $display("txn reset_mid_req stray_ack ignored");
    run_access(make_vec("ld_after_rst", 1, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0));

    // Back-to-back loads with mem_rd held throughout.
    run_access(make_vec("b2b_0", 1, 2'b00, 1, 32'h0000_0303, 32'h0, 32'h8081_8283, 0));
    run_access(make_vec("b2b_1", 1, 2'b01, 0, 32'h0000_0400, 32'h0, 32'h9192_9394, 0));
    run_access(make_vec("b2b_2", 1, 2'b10, 1, 32'h0000_0504, 32'h0, 32'hA1A2_A3A4, 1));
    go_idle();

    // Randomized aligned accesses.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (sz == 2'b01) a[0] = 1'b0;
      else if (sz != 2'b00) a[1:0] = 2'b00;
      rv = make_vec($sformatf("rand_%0d", i), 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
      run_access(rv);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
